// File: rtl/top_if.sv
// Operand/result handshake bundle for the GCD processor.
interface top_if;
  logic       Start;
  logic       Busy;
  logic [7:0] InA;
  logic [7:0] InB;
  logic [7:0] Out;

  modport master (
    output Start, InA, InB,
    input  Busy, Out
  );

  modport slave (
    input  Start, InA, InB,
    output Busy, Out
  );
endinterface

// File: rtl/top.sv
// GCD processor: controller FSM plus subtract-and-compare datapath.
// One subtraction per cycle until an operand is zero or both match.
module top (
  input  logic clk,
  input  logic reset,
  top_if.slave bus
);
  typedef enum logic {IDLE, CALC} state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] r_q, r_d;

  logic a_z, b_z, both;
  logic fin_a, fin_b, fin_eq;
  logic sub_a, sub_b;

  assign a_z    = (a_q == 8'd0);
  assign b_z    = (b_q == 8'd0);
  assign both   = !a_z && !b_z;
  // Mutually exclusive decode of the completion/step priority chain.
  assign fin_a  = a_z;
  assign fin_b  = !a_z && b_z;
  assign fin_eq = both && (a_q == b_q);
  assign sub_a  = both && (a_q > b_q);
  assign sub_b  = both && (a_q < b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      r_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = bus.InA;
          b_d     = bus.InB;
          state_d = CALC;
        end
      end
      CALC: begin
        unique case (1'b1)
          fin_a: begin
            r_d     = b_q;
            state_d = IDLE;
          end
          fin_b, fin_eq: begin
            r_d     = a_q;
            state_d = IDLE;
          end
          sub_a: a_d = a_q - b_q;
          sub_b: b_d = b_q - a_q;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy = (state_q == CALC);
  assign bus.Out  = r_q;
endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the GCD processor: random and directed
// operand pairs checked against a Euclid-style reference model.
module tb_top;
  typedef struct {
    logic [7:0] g;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_d = 1'b1;
  top_if bus ();

  top dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [7:0] exp_out = 8'd0;
  int cnt = 0;
  logic prev = 1'b0;

  // Reference: gcd plus number of repeated subtractions, counted
  // per Euclid division step instead of one subtraction at a time.
  function automatic exp_t model(input logic [7:0] ia,
                                 input logic [7:0] ib);
    exp_t e;
    int a, b, n;
    a = int'(ia);
    b = int'(ib);
    n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) begin
        if (a % b == 0) begin
          n += a / b - 1;
          a = b;
        end else begin
          n += a / b;
          a = a % b;
        end
      end else begin
        if (b % a == 0) begin
          n += b / a - 1;
          b = a;
        end else begin
          n += b / a;
          b = b % a;
        end
      end
    end
    e.g = (a == 0) ? 8'(b) : 8'(a);
    e.cyc = n + 1;
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Issue side: record the expected response on every accepting edge.
  always @(posedge clk) begin
    rst_d <= reset;
    if (reset)
      sb.delete();
    else if (bus.Start && !bus.Busy)
      sb.push_back(model(bus.InA, bus.InB));
  end

  // Monitor: compare result and busy length when Busy falls.
  always @(negedge clk) begin
    exp_t e;
    if (rst_d) begin
      exp_out = 8'd0;
      cnt = 0;
      prev = 1'b0;
      check("reset_busy", int'(bus.Busy), 0);
    end else if (bus.Busy) begin
      cnt++;
      if (!prev && sb.size() == 0)
        check("busy_without_start", 1, 0);
      prev = 1'b1;
    end else if (prev) begin
      prev = 1'b0;
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        exp_out = e.g;
        check("busy_cycles", cnt, e.cyc);
      end
      cnt = 0;
    end
    check("out", int'(bus.Out), int'(exp_out));
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.Busy && k < 400) begin
      bus.Start = 1'($urandom);
      bus.InA = 8'($urandom);
      bus.InB = 8'($urandom);
      @(posedge clk);
      #1;
      k++;
    end
    if (bus.Busy)
      check("idle_timeout", 1, 0);
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    bus.Start = 1'b1;
    bus.InA = a;
    bus.InB = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.InA = 8'($urandom);
    bus.InB = 8'($urandom);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.InA = 8'd0;
    bus.InB = 8'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    go(8'hF0, 8'h0F);
    go(8'h24, 8'h18);
    go(8'h07, 8'h07);
    go(8'h00, 8'h2A);
    go(8'h2A, 8'h00);
    go(8'h00, 8'h00);
    wait_idle();
    bus.Start = 1'b0;
    @(posedge clk);
    #1;
    // Start held high: second job must be taken right after Busy falls.
    bus.Start = 1'b1;
    bus.InA = 8'hFF;
    bus.InB = 8'h01;
    @(posedge clk);
    #1;
    bus.InA = 8'h24;
    bus.InB = 8'h18;
    begin
      int k;
      k = 0;
      while (bus.Busy && k < 400) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("b2b_fall", int'(bus.Busy), 0);
    end
    @(posedge clk);
    #1;
    check("b2b_accept", int'(bus.Busy), 1);
    bus.Start = 1'b0;
    // Abort mid-computation.
    go(8'hF0, 8'h0F);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", int'(bus.Busy), 0);
    check("abort_out", int'(bus.Out), 0);
    go(8'h24, 8'h18);
    wait_idle();
    bus.Start = 1'b0;
    @(posedge clk);
    #1;
    // Reset concurrent with Start loads nothing.
    reset = 1'b1;
    bus.Start = 1'b1;
    bus.InA = 8'h05;
    bus.InB = 8'h0A;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.Start = 1'b0;
    check("rst_start_busy", int'(bus.Busy), 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      go(a, b);
    end
    wait_idle();
    bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
